// File: rtl/hack_program_loader_if.sv
// Instruction-field stream (producer -> loader) and ROM write bus (loader -> ROM)
// bundled for the Hack program loader.
interface hack_program_loader_if #(
  parameter int ADDR_W = 15
) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_is_c;
  logic [14:0]       in_value;
  logic              in_a;
  logic [5:0]        in_comp;
  logic [2:0]        in_dest;
  logic [2:0]        in_jump;
  logic              in_last;
  logic              rom_we;
  logic              rom_ack;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;

  modport master (
    output in_valid, in_is_c, in_value, in_a, in_comp, in_dest, in_jump, in_last, rom_ack,
    input  in_ready, rom_we, rom_addr, rom_wdata
  );

  modport slave (
    input  in_valid, in_is_c, in_value, in_a, in_comp, in_dest, in_jump, in_last, rom_ack,
    output in_ready, rom_we, rom_addr, rom_wdata
  );
endinterface

// File: rtl/hack_program_loader.sv
// Encodes Hack instruction fields into 16-bit words, buffers them in a small FIFO
// and writes them sequentially into instruction ROM from a programmable base address.
module hack_program_loader #(
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  hack_program_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W:0]      words_written
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WORDS_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic               stage_valid_q, stage_valid_d;
  logic [15:0]        stage_data_q, stage_data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    words_q, words_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic [15:0]        enc_word_s;
  logic               fifo_empty_s;
  logic               fifo_full_next_s;
  logic               push_s;
  logic               pop_s;
  logic               wr_done_s;
  logic               stage_free_s;
  logic               discard_s;

  function automatic logic [15:0] encode_word(
    input logic        is_c,
    input logic [14:0] value,
    input logic        a,
    input logic [5:0]  comp,
    input logic [2:0]  dest,
    input logic [2:0]  jump
  );
    logic [15:0] w;
    if (is_c) begin
      w = {3'b111, a, comp, dest, jump};
    end else begin
      w = {1'b0, value};
    end
    return w;
  endfunction

  function automatic logic ptr_full(input logic [PTR_W:0] wp, input logic [PTR_W:0] rp);
    return (wp[PTR_W] != rp[PTR_W]) && (wp[PTR_W-1:0] == rp[PTR_W-1:0]);
  endfunction

  assign enc_word_s   = encode_word(bus.in_is_c, bus.in_value, bus.in_a,
                                    bus.in_comp, bus.in_dest, bus.in_jump);
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  // ready_q is only ever high in LOAD with the FIFO not full.
  assign push_s       = bus.in_valid & ready_q;
  assign wr_done_s    = stage_valid_q & bus.rom_ack;
  assign stage_free_s = ~stage_valid_q | wr_done_s;
  assign pop_s        = ~fifo_empty_s & stage_free_s;
  // Once the last ROM address has been written, remaining words are dropped.
  assign discard_s    = err_q | (wr_done_s & (addr_q == ADDR_MAX));

  assign bus.in_ready  = ready_q;
  assign bus.rom_we    = stage_valid_q;
  assign bus.rom_addr  = addr_q;
  assign bus.rom_wdata = stage_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = words_q;

  // Next-state, FIFO pointer, output-stage and session-counter logic.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    stage_valid_d = stage_valid_q;
    stage_data_d  = stage_data_q;
    addr_d        = addr_q;
    words_d       = words_q;
    err_d         = err_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (wr_done_s) begin
      stage_valid_d = 1'b0;
      words_d       = words_q + WORDS_ONE;
      if (addr_q == ADDR_MAX) begin
        err_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_ONE;
      end
    end else begin
      words_d = words_q;
    end

    if (pop_s && !discard_s) begin
      stage_valid_d = 1'b1;
      stage_data_d  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    end else begin
      stage_data_d  = stage_data_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          words_d = '0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (push_s && bus.in_last) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s && !stage_valid_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    fifo_full_next_s = ptr_full(wr_ptr_d, rd_ptr_d);
    ready_d = (state_d == ST_LOAD) & ~fifo_full_next_s;
    busy_d  = (state_d == ST_LOAD) | (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
  end

  // Control and output-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= 16'h0000;
      addr_q        <= '0;
      words_q       <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      addr_q        <= addr_d;
      words_q       <= words_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ready_q       <= ready_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= enc_word_s;
    end
  end
endmodule

// File: tb/tb_hack_program_loader.sv
// Scoreboard bench for hack_program_loader: randomized field streams, a reference
// model of encoding/addressing, and a decoupled ROM-side monitor.
module tb_hack_program_loader;
  localparam int AW     = 15;
  localparam int DEPTH  = 4;
  localparam int AMAX_I = (1 << AW) - 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, err;
  logic [AW:0]   words_written;

  hack_program_loader_if #(.ADDR_W(AW)) bus ();

  hack_program_loader #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(bus),
    .busy(busy), .done(done), .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, writes_seen = 0, done_cnt = 0, run_len = 0;
  int last_wr_edge = -10, last_done_edge = -10;
  int ack_mode = 1, gap_max = 0, accepted = 0;
  int m_base = 0, m_k = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] model_enc(input bit is_c, input logic [14:0] val, input bit a,
                                            input logic [5:0] comp, input logic [2:0] dest,
                                            input logic [2:0] jump);
    int w;
    if (is_c) w = 57344 + int'(a) * 4096 + int'(comp) * 64 + int'(dest) * 8 + int'(jump);
    else      w = int'(val);
    return w[15:0];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.rom_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       bus.rom_ack = 1'b0;
        1:       bus.rom_ack = 1'b1;
        default: bus.rom_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ROM-side monitor: pops the scoreboard on every write handshake.
  initial begin
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [15:0]   prev_data;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("rom_we_hold", bus.rom_we, 1);
          check("rom_addr_hold", bus.rom_addr, prev_addr);
          check("rom_wdata_hold", bus.rom_wdata, prev_data);
        end
        prev_stall = bus.rom_we && !bus.rom_ack;
        prev_addr  = bus.rom_addr;
        prev_data  = bus.rom_wdata;
        if (bus.rom_we && bus.rom_ack) begin
          writes_seen++;
          run_len      = (last_wr_edge == cyc) ? run_len + 1 : 1;
          last_wr_edge = cyc + 1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                     bus.rom_addr, bus.rom_wdata);
          end else begin
            e = exp_q.pop_front();
            check("rom_addr", bus.rom_addr, e.addr);
            check("rom_wdata", bus.rom_wdata, e.data);
          end
        end
        if (done) begin
          done_cnt++;
          last_done_edge = cyc;
        end
      end
    end
  end

  task automatic begin_session(input int b);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(b);
    @(posedge clk); #1;
    start = 1'b0;
    m_base = b;
    m_k = 0;
  endtask

  task automatic send_word(input bit is_c, input logic [14:0] val, input bit a,
                           input logic [5:0] comp, input logic [2:0] dest,
                           input logic [2:0] jump, input bit last, output int acc_edge);
    int   waited = 0;
    int   gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    exp_t e;
    acc_edge = -1;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    bus.in_is_c = is_c; bus.in_value = val; bus.in_a = a; bus.in_comp = comp;
    bus.in_dest = dest; bus.in_jump = jump; bus.in_last = last; bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.in_ready && waited < 300);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", waited);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_edge = cyc;
    accepted++;
    bus.in_valid = 1'b0;
    if (m_base + m_k <= AMAX_I) begin
      e.addr = AW'(m_base + m_k);
      e.data = model_enc(is_c, val, a, comp, dest, jump);
      exp_q.push_back(e);
    end
    m_k++;
  endtask

  task automatic send_rand(input bit last, output int acc_edge);
    send_word(1'($urandom), 15'($urandom), 1'($urandom), 6'($urandom), 3'($urandom),
              3'($urandom), last, acc_edge);
  endtask

  task automatic finish_session(input int n, input int d0);
    int t = 0;
    int eww;
    while (done_cnt == d0 && t < 600) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done pulse after %0d cycles, required one", t);
    end
    repeat (3) @(posedge clk);
    #1;
    eww = (n < AMAX_I - m_base + 1) ? n : AMAX_I - m_base + 1;
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after", busy, 0);
    check("words_written", words_written, eww);
    check("err", err, (m_base + n - 1 >= AMAX_I) ? 1 : 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int d0, acc, w0, t, n, b;
    bus.in_valid = 1'b0; bus.in_is_c = 1'b0; bus.in_value = '0; bus.in_a = 1'b0;
    bus.in_comp = '0; bus.in_dest = '0; bus.in_jump = '0; bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_we", bus.rom_we, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words", words_written, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    rst_n = 1'b1;

    // Basic stream from the plan.
    ack_mode = 1; gap_max = 0; d0 = done_cnt;
    begin_session(16'h0010);
    send_word(1'b0, 15'h0056, 1'b0, 6'b000000, 3'b000, 3'b000, 1'b0, acc);
    send_word(1'b1, 15'h0000, 1'b0, 6'b011111, 3'b010, 3'b000, 1'b0, acc);
    send_word(1'b1, 15'h0000, 1'b0, 6'b001100, 3'b000, 3'b001, 1'b1, acc);
    finish_session(3, d0);

    // Single word: write two edges after accept, done one edge after the write.
    d0 = done_cnt;
    begin_session(int'($urandom_range(0, 1000)));
    send_word(1'b0, 15'h7FFF, 1'b0, 6'b000000, 3'b000, 3'b000, 1'b1, acc);
    finish_session(1, d0);
    check("wr_latency", last_wr_edge - acc, 2);
    check("done_latency", last_done_edge - last_wr_edge, 1);

    // Ignored inputs: valid in IDLE, start during LOAD.
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("in_ready_idle", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    d0 = done_cnt;
    begin_session(16'h0200);
    check("busy_load", busy, 1);
    send_rand(1'b0, acc);
    send_rand(1'b0, acc);
    @(posedge clk); #1; start = 1'b1; base_addr = AW'(16'h7000);
    @(posedge clk); #1; start = 1'b0;
    send_rand(1'b0, acc);
    send_rand(1'b1, acc);
    finish_session(4, d0);

    // Backpressure: seven words offered with the ROM stalled.
    ack_mode = 0; d0 = done_cnt; accepted = 0;
    begin_session(int'($urandom_range(0, 20000)));
    fork
      begin
        for (int i = 0; i < 7; i++) send_rand(i == 6, acc);
      end
      begin
        repeat (25) @(posedge clk);
        #1;
        check("accepted_stalled", accepted, 5);
        check("in_ready_full", bus.in_ready, 0);
        check("rom_we_stalled", bus.rom_we, 1);
        ack_mode = 1;
      end
    join
    finish_session(7, d0);
    check("no_gap_run", run_len, 7);

    // Overflow at the top of the address space.
    d0 = done_cnt;
    begin_session(AMAX_I - 1);
    for (int i = 0; i < 4; i++) send_rand(i == 3, acc);
    finish_session(4, d0);
    d0 = done_cnt;
    begin_session(0);
    check("err_cleared", err, 0);
    check("words_cleared", words_written, 0);
    send_rand(1'b1, acc);
    finish_session(1, d0);

    // Randomized sessions, some running into the top of memory.
    ack_mode = 2; gap_max = 2;
    for (int s = 0; s < 8; s++) begin
      n = int'($urandom_range(1, 10));
      b = ($urandom_range(0, 3) == 0) ? AMAX_I - int'($urandom_range(0, 6))
                                      : int'($urandom_range(0, AMAX_I));
      d0 = done_cnt;
      begin_session(b);
      for (int i = 0; i < n; i++) send_rand(i == n - 1, acc);
      finish_session(n, d0);
    end

    // Reset after two of five words have been written.
    ack_mode = 0; gap_max = 0;
    begin_session(16'h0100);
    for (int i = 0; i < 5; i++) send_rand(i == 4, acc);
    ack_mode = 1;
    w0 = writes_seen; t = 0;
    while (writes_seen < w0 + 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("writes_before_reset", writes_seen - w0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rom_we", bus.rom_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_words", words_written, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_rom_addr", bus.rom_addr, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    d0 = done_cnt;
    begin_session(0);
    for (int i = 0; i < 3; i++) send_rand(i == 2, acc);
    finish_session(3, d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the end of the test sequence");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hack_program_loader.md
Name: hack_program_loader

Overview:
- Writer-side counterpart to the Hack instruction decoder.
- Accepts instruction fields (A-value, or a/comp/dest/jump) over a valid/ready stream and encodes them into 16-bit Hack words.
- Buffers the words in a small FIFO, then writes them sequentially into instruction ROM from a programmable base address.
- Used to load programs into the CPU's instruction memory before or between runs.

Parameters:
- ADDR_W, 15, ROM address width; addresses span 0 .. 2^ADDR_W-1.
- FIFO_DEPTH, 4, encoded-word FIFO depth; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load session
- base_addr  in  ADDR_W  first ROM address; sampled on an accepted start
- in_valid  in  1  instruction field set is valid
- in_ready  out  1  loader can accept a field set
- in_is_c  in  1  1 = C-instruction, 0 = A-instruction
- in_value  in  15  A-instruction constant
- in_a  in  1  C-instruction a bit
- in_comp  in  6  C-instruction comp field
- in_dest  in  3  C-instruction dest field {A,D,M}
- in_jump  in  3  C-instruction jump field
- in_last  in  1  marks the final instruction of the session
- rom_we  out  1  write request (valid)
- rom_ack  in  1  ROM accepts the write (ready)
- rom_addr  out  ADDR_W  write address
- rom_wdata  out  16  encoded instruction
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky address-overflow flag; cleared on the next accepted start
- words_written  out  ADDR_W+1  ROM writes completed in the current/last session

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; FIFO and output stage are emptied; state goes to IDLE.
  - Takes effect immediately, including mid-session; pending writes are lost.
- Encoding, combinational at the input:
  - A-instruction: {1'b0, in_value}.
  - C-instruction: {3'b111, in_a, in_comp, in_dest, in_jump}.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - On start=1: load addr<=base_addr, words_written<=0, err<=0, then go to LOAD.
- LOAD:
  - busy=1; in_ready = !fifo_full.
  - A handshake (in_valid & in_ready) pushes the encoded word.
  - Accepting a word with in_last=1 moves to DRAIN.
  - start is ignored while busy.
- Output stage:
  - Registered; holds one word separate from the FIFO.
  - When the stage is empty and the FIFO is non-empty, the stage loads the FIFO head and asserts rom_we on the next cycle.
  - rom_we, rom_addr and rom_wdata stay stable until rom_ack=1.
  - On rom_we & rom_ack: increment addr and words_written; refill the stage from the FIFO in the same cycle if a word is available (back-to-back writes with no gaps).
- Latency:
  - A word accepted at edge N can appear on rom_we at edge N+2 at the earliest.
  - Total buffering is FIFO_DEPTH+1 words.
- FIFO rules:
  - in_ready depends only on full, with no push/pop bypass.
  - A push on full or a pop on empty never happens.
- Overflow:
  - After a write completes at addr = 2^ADDR_W-1, the address does not wrap.
  - err goes to 1 and stays there.
  - Every later word is popped and discarded with no rom_we.
  - in_ready keeps following FIFO state until in_last is accepted.
- DRAIN:
  - in_ready=0.
  - When the FIFO and the output stage are both empty, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0; return to IDLE.
  - words_written and err hold until the next start.

Test Plan:
- Basic, Hazard-free:
  - Stimulus: rom_ack=1, base_addr=0x0010; stream A(0x0056), C(a=0, comp=011111, dest=010, jump=000), C(a=0, comp=001100, dest=000, jump=001, last).
  - Response: writes 0x0056@0x10, 0xE7D0@0x11, 0xE301@0x12; done pulses once; words_written=3; err=0.
- Backpressure:
  - Stimulus: rom_ack=0; in_valid held with 7 words.
  - Response: exactly 5 words accepted before in_ready=0; rom_we/rom_addr/rom_wdata stable. Releasing rom_ack writes all 7 in order at consecutive addresses with no gaps.
- Overflow:
  - Stimulus: ADDR_W=4, base_addr=0xE; 4 words, last on the 4th.
  - Response: writes at 0xE and 0xF only; err=1; words_written=2; done pulses; no write at 0x0.
- Reset mid-session:
  - Stimulus: assert rst_n=0 after 2 of 5 words are written.
  - Response: rom_we drops asynchronously and all outputs go to 0. A new start with base 0x0 writes only the new stream.
- Ignored inputs:
  - Stimulus: in_valid=1 in IDLE; start pulsed during LOAD.
  - Response: in_ready=0 in IDLE; the second start does not change addr, words_written or err.
- Single word, latency:
  - Stimulus: one A(0x7FFF) with in_last; rom_ack=1.
  - Response: rom_we two cycles after the accept edge with rom_wdata=0x7FFF; done the cycle after DRAIN empties.
